// File: rtl/axi4_stream_to_axi4_pkg.sv
// Shared AXI constants and FSM state encoding for the frame-buffer write DMA stage.
package axi4_stream_to_axi4_pkg;

  localparam logic [1:0] BURST_INCR      = 2'b01;
  localparam logic [1:0] RESP_OKAY       = 2'b00;
  localparam int         MAX_BURST_WORDS = 256;

  typedef enum logic [2:0] {
    IDLE_S = 3'd0,
    FILL_S = 3'd1,
    ADDR_S = 3'd2,
    DATA_S = 3'd3,
    RESP_S = 3'd4,
    DROP_S = 3'd5
  } state_e;

endpackage

// File: rtl/axi4_stream_to_axi4_burst_fifo.sv
// Burst staging FIFO: registered head word presented first-word fall-through,
// with a bypass so a push into an empty FIFO is visible on the next cycle.
module burst_fifo #(
  parameter int WIDTH = 72,
  parameter int DEPTH = 256
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      mem_cnt_q;
  logic [WIDTH-1:0] head_q;
  logic             head_vld_q;

  logic load_head, mem_empty, bypass, mem_wr, mem_rd;

  assign load_head = pop_i || !head_vld_q;
  assign mem_empty = (mem_cnt_q == '0);
  assign bypass    = push_i && load_head && mem_empty;
  assign mem_wr    = push_i && !bypass;
  assign mem_rd    = load_head && !mem_empty;

  assign data_o  = head_q;
  assign empty_o = !head_vld_q;
  assign full_o  = (mem_cnt_q + (AW+1)'(head_vld_q)) == (AW+1)'(DEPTH);

  always_ff @(posedge clk_i) begin
    if (mem_wr) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_cnt_q  <= '0;
      head_q     <= '0;
      head_vld_q <= 1'b0;
    end else begin
      if (mem_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (mem_rd) begin
        head_q   <= mem_q[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end else if (bypass) begin
        head_q <= data_i;
      end
      if (load_head) head_vld_q <= !mem_empty || push_i;
      if (mem_wr && !mem_rd)      mem_cnt_q <= mem_cnt_q + (AW+1)'(1);
      else if (mem_rd && !mem_wr) mem_cnt_q <= mem_cnt_q - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/axi4_stream_to_axi4.sv
// Frame-buffer write DMA: stores one AXI4-Stream packet per wr_stb_i as a series of
// serialised AXI4 INCR bursts (<=256 beats) and reports the stored byte count.
//
// state  | meaning
// IDLE_S | waiting for wr_stb_i
// FILL_S | accepting stream beats into the burst FIFO
// ADDR_S | AW request presented
// DATA_S | draining FIFO onto the W channel
// RESP_S | waiting for the burst write response
// DROP_S | discarding the tail of a truncated packet
module axi4_stream_to_axi4
  import axi4_stream_to_axi4_pkg::*;
#(
  parameter int DATA_WIDTH         = 64,
  parameter int ADDR_WIDTH         = 32,
  parameter int ID_WIDTH           = 1,
  parameter int AWUSER_WIDTH       = 1,
  parameter int WUSER_WIDTH        = 1,
  parameter int ARUSER_WIDTH       = 1,
  parameter int MAX_PKT_SIZE_B     = 2048,
  parameter int MAX_PKT_SIZE_WIDTH = $clog2(MAX_PKT_SIZE_B)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [ADDR_WIDTH-1:0]         addr_i,
  input  logic                          wr_stb_i,
  input  logic                          pkt_tvalid_i,
  output logic                          pkt_tready_o,
  input  logic [DATA_WIDTH-1:0]         pkt_tdata_i,
  input  logic [DATA_WIDTH/8-1:0]       pkt_tkeep_i,
  input  logic                          pkt_tlast_i,
  output logic [ID_WIDTH-1:0]           mem_awid_o,
  output logic [ADDR_WIDTH-1:0]         mem_awaddr_o,
  output logic [7:0]                    mem_awlen_o,
  output logic [2:0]                    mem_awsize_o,
  output logic [1:0]                    mem_awburst_o,
  output logic                          mem_awlock_o,
  output logic [3:0]                    mem_awcache_o,
  output logic [2:0]                    mem_awprot_o,
  output logic [3:0]                    mem_awqos_o,
  output logic [3:0]                    mem_awregion_o,
  output logic [AWUSER_WIDTH-1:0]       mem_awuser_o,
  output logic                          mem_awvalid_o,
  input  logic                          mem_awready_i,
  output logic [DATA_WIDTH-1:0]         mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0]       mem_wstrb_o,
  output logic                          mem_wlast_o,
  output logic [WUSER_WIDTH-1:0]        mem_wuser_o,
  output logic                          mem_wvalid_o,
  input  logic                          mem_wready_i,
  input  logic [1:0]                    mem_bresp_i,
  input  logic                          mem_bvalid_i,
  output logic                          mem_bready_o,
  output logic [ID_WIDTH-1:0]           mem_arid_o,
  output logic [ADDR_WIDTH-1:0]         mem_araddr_o,
  output logic [7:0]                    mem_arlen_o,
  output logic [2:0]                    mem_arsize_o,
  output logic [1:0]                    mem_arburst_o,
  output logic                          mem_arlock_o,
  output logic [3:0]                    mem_arcache_o,
  output logic [2:0]                    mem_arprot_o,
  output logic [3:0]                    mem_arqos_o,
  output logic [3:0]                    mem_arregion_o,
  output logic [ARUSER_WIDTH-1:0]       mem_aruser_o,
  output logic                          mem_arvalid_o,
  output logic                          mem_rready_o,
  output logic [MAX_PKT_SIZE_WIDTH:0]   pkt_size_o,
  output logic                          pkt_done_o,
  output logic                          busy_o,
  output logic                          truncated_o,
  output logic                          err_o
);

  localparam int BYTES     = DATA_WIDTH / 8;
  localparam int BSH       = $clog2(BYTES);
  localparam int MAX_WORDS = MAX_PKT_SIZE_B / BYTES;
  localparam int PSW       = MAX_PKT_SIZE_WIDTH + 1;
  localparam int FW        = DATA_WIDTH + BYTES;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] cur_addr_q, awaddr_q;
  logic [8:0]            burst_words_q;
  logic [PSW-1:0]        pkt_words_q, pkt_size_q;
  logic [7:0]            awlen_q, wcnt_q;
  logic [BYTES-1:0]      final_strb_q;
  logic                  awvalid_q, tlast_seen_q, truncated_q, err_q, pkt_done_q;

  logic             beat_acc, fill_acc, at_max, trunc_beat, close_burst;
  logic             w_hs, wlast, final_burst;
  logic [8:0]       burst_words_inc;
  logic [PSW-1:0]   pkt_words_inc, size_d;
  logic [BYTES-1:0] keep_in;
  logic [FW-1:0]    fifo_dout;
  logic             fifo_empty, fifo_full, fifo_push;

  assign pkt_tready_o    = (state_q == FILL_S) || (state_q == DROP_S);
  assign beat_acc        = pkt_tvalid_i && pkt_tready_o;
  assign fill_acc        = beat_acc && (state_q == FILL_S);
  assign burst_words_inc = burst_words_q + 9'd1;
  assign pkt_words_inc   = pkt_words_q + PSW'(1);
  assign at_max          = (pkt_words_inc == PSW'(MAX_WORDS));
  assign trunc_beat      = at_max && !pkt_tlast_i;
  assign close_burst     = pkt_tlast_i || (burst_words_inc == 9'(MAX_BURST_WORDS)) || at_max;
  // A truncated packet's final stored beat is a full word, whatever tkeep said.
  assign keep_in         = trunc_beat ? {BYTES{1'b1}} : pkt_tkeep_i;
  assign fifo_push       = fill_acc && !fifo_full;

  burst_fifo #(.WIDTH(FW), .DEPTH(MAX_BURST_WORDS)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .pop_i   (w_hs),
    .data_i  ({pkt_tdata_i, keep_in}),
    .data_o  (fifo_dout),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign final_burst  = tlast_seen_q || truncated_q;
  assign wlast        = (wcnt_q == awlen_q);
  assign mem_wvalid_o = (state_q == DATA_S) && !fifo_empty;
  assign w_hs         = mem_wvalid_o && mem_wready_i;
  assign mem_wdata_o  = fifo_dout[FW-1:BYTES];
  assign mem_wstrb_o  = (final_burst && wlast) ? fifo_dout[BYTES-1:0] : {BYTES{1'b1}};
  assign mem_wlast_o  = wlast;
  assign mem_wuser_o  = '0;
  assign mem_bready_o = 1'b1;

  assign size_d = ((pkt_words_q - PSW'(1)) << BSH) + PSW'($countones(final_strb_q));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE_S;
      cur_addr_q    <= '0;
      awaddr_q      <= '0;
      burst_words_q <= '0;
      pkt_words_q   <= '0;
      pkt_size_q    <= '0;
      awlen_q       <= '0;
      wcnt_q        <= '0;
      final_strb_q  <= '0;
      awvalid_q     <= 1'b0;
      tlast_seen_q  <= 1'b0;
      truncated_q   <= 1'b0;
      err_q         <= 1'b0;
      pkt_done_q    <= 1'b0;
    end else begin
      pkt_done_q <= 1'b0;
      unique case (state_q)
        IDLE_S: if (wr_stb_i) begin
          cur_addr_q    <= addr_i & ~ADDR_WIDTH'(BYTES - 1);
          burst_words_q <= '0;
          pkt_words_q   <= '0;
          tlast_seen_q  <= 1'b0;
          truncated_q   <= 1'b0;
          err_q         <= 1'b0;
          state_q       <= FILL_S;
        end
        FILL_S: if (fill_acc) begin
          burst_words_q <= burst_words_inc;
          pkt_words_q   <= pkt_words_inc;
          if (pkt_tlast_i) tlast_seen_q <= 1'b1;
          if (trunc_beat)  truncated_q  <= 1'b1;
          if (close_burst) begin
            awaddr_q  <= cur_addr_q;
            awlen_q   <= burst_words_q[7:0];
            awvalid_q <= 1'b1;
            state_q   <= ADDR_S;
          end
        end
        ADDR_S: if (mem_awready_i) begin
          awvalid_q <= 1'b0;
          wcnt_q    <= '0;
          state_q   <= DATA_S;
        end
        DATA_S: if (w_hs) begin
          wcnt_q <= wcnt_q + 8'd1;
          if (wlast) begin
            if (final_burst) final_strb_q <= mem_wstrb_o;
            state_q <= RESP_S;
          end
        end
        RESP_S: if (mem_bvalid_i) begin
          if (mem_bresp_i != RESP_OKAY) err_q <= 1'b1;
          cur_addr_q    <= cur_addr_q + (ADDR_WIDTH'(burst_words_q) << BSH);
          burst_words_q <= '0;
          if (tlast_seen_q) begin
            pkt_size_q <= size_d;
            pkt_done_q <= 1'b1;
            state_q    <= IDLE_S;
          end else if (truncated_q) begin
            pkt_size_q <= size_d;
            state_q    <= DROP_S;
          end else begin
            state_q <= FILL_S;
          end
        end
        DROP_S: if (beat_acc && pkt_tlast_i) begin
          pkt_done_q <= 1'b1;
          state_q    <= IDLE_S;
        end
        default: state_q <= IDLE_S;
      endcase
    end
  end

  assign mem_awid_o     = '0;
  assign mem_awaddr_o   = awaddr_q;
  assign mem_awlen_o    = awlen_q;
  assign mem_awsize_o   = 3'(BSH);
  assign mem_awburst_o  = BURST_INCR;
  assign mem_awlock_o   = 1'b0;
  assign mem_awcache_o  = '0;
  assign mem_awprot_o   = '0;
  assign mem_awqos_o    = '0;
  assign mem_awregion_o = '0;
  assign mem_awuser_o   = '0;
  assign mem_awvalid_o  = awvalid_q;

  assign mem_arid_o     = '0;
  assign mem_araddr_o   = '0;
  assign mem_arlen_o    = '0;
  assign mem_arsize_o   = '0;
  assign mem_arburst_o  = '0;
  assign mem_arlock_o   = 1'b0;
  assign mem_arcache_o  = '0;
  assign mem_arprot_o   = '0;
  assign mem_arqos_o    = '0;
  assign mem_arregion_o = '0;
  assign mem_aruser_o   = '0;
  assign mem_arvalid_o  = 1'b0;
  assign mem_rready_o   = 1'b1;

  assign pkt_size_o  = pkt_size_q;
  assign pkt_done_o  = pkt_done_q;
  assign busy_o      = (state_q != IDLE_S);
  assign truncated_o = truncated_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_axi4_stream_to_axi4.sv
// Scoreboard bench: packet-level model pushes expected AW/W/done records, monitors pop and compare.
module tb_axi4_stream_to_axi4;

  localparam int DW   = 64;
  localparam int AWD  = 32;
  localparam int MAXB = 4096;
  localparam int PSW  = $clog2(MAXB) + 1;
  localparam int MAXW = MAXB / 8;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  logic [AWD-1:0] addr_i = '0;
  logic           wr_stb_i = 1'b0;
  logic           pkt_tvalid_i = 1'b0, pkt_tlast_i = 1'b0;
  logic [DW-1:0]  pkt_tdata_i = '0;
  logic [7:0]     pkt_tkeep_i = '0;
  logic           pkt_tready_o;
  logic           mem_awready_i = 1'b0, mem_wready_i = 1'b0, mem_bvalid_i = 1'b0;
  logic [1:0]     mem_bresp_i = 2'b00;

  logic [0:0]     awid, arid, awuser, wuser, aruser;
  logic [AWD-1:0] awaddr, araddr;
  logic [7:0]     awlen, arlen, wstrb;
  logic [2:0]     awsize, arsize, awprot, arprot;
  logic [1:0]     awburst, arburst;
  logic           awlock, arlock, awvalid, arvalid, wlast, wvalid, bready, rready;
  logic [3:0]     awcache, arcache, awqos, arqos, awregion, arregion;
  logic [DW-1:0]  wdata;
  logic [PSW-1:0] pkt_size_o;
  logic           pkt_done_o, busy_o, truncated_o, err_o;

  axi4_stream_to_axi4 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AWD), .MAX_PKT_SIZE_B(MAXB)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .addr_i(addr_i), .wr_stb_i(wr_stb_i),
    .pkt_tvalid_i(pkt_tvalid_i), .pkt_tready_o(pkt_tready_o), .pkt_tdata_i(pkt_tdata_i),
    .pkt_tkeep_i(pkt_tkeep_i), .pkt_tlast_i(pkt_tlast_i),
    .mem_awid_o(awid), .mem_awaddr_o(awaddr), .mem_awlen_o(awlen), .mem_awsize_o(awsize),
    .mem_awburst_o(awburst), .mem_awlock_o(awlock), .mem_awcache_o(awcache), .mem_awprot_o(awprot),
    .mem_awqos_o(awqos), .mem_awregion_o(awregion), .mem_awuser_o(awuser), .mem_awvalid_o(awvalid),
    .mem_awready_i(mem_awready_i), .mem_wdata_o(wdata), .mem_wstrb_o(wstrb), .mem_wlast_o(wlast),
    .mem_wuser_o(wuser), .mem_wvalid_o(wvalid), .mem_wready_i(mem_wready_i),
    .mem_bresp_i(mem_bresp_i), .mem_bvalid_i(mem_bvalid_i), .mem_bready_o(bready),
    .mem_arid_o(arid), .mem_araddr_o(araddr), .mem_arlen_o(arlen), .mem_arsize_o(arsize),
    .mem_arburst_o(arburst), .mem_arlock_o(arlock), .mem_arcache_o(arcache), .mem_arprot_o(arprot),
    .mem_arqos_o(arqos), .mem_arregion_o(arregion), .mem_aruser_o(aruser), .mem_arvalid_o(arvalid),
    .mem_rready_o(rready), .pkt_size_o(pkt_size_o), .pkt_done_o(pkt_done_o), .busy_o(busy_o),
    .truncated_o(truncated_o), .err_o(err_o)
  );

  typedef struct packed { logic [AWD-1:0] addr; logic [7:0] len; } aw_t;
  typedef struct packed { logic [DW-1:0] data; logic [7:0] strb; logic last; } w_t;
  typedef struct packed { logic [PSW-1:0] size; logic trunc; logic err; } done_t;

  aw_t        aw_q[$];
  w_t         w_q[$];
  done_t      done_q[$];
  logic [1:0] bresp_q[$];

  int vectors = 0, miscompares = 0;
  int aw_stall = 0, w_seen = 0;
  bit aw_rand = 0, w_rand = 0, gap_rand = 0;

  function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endfunction

  // Monitors: compare whatever the DUT presents against the queued expectations.
  always @(negedge clk_i) begin
    aw_t ea; w_t ew; done_t ed;
    if (!rst_i) begin
      if (awvalid && mem_awready_i) begin
        check("awsize", awsize, 3);
        check("awburst", awburst, 1);
        if (aw_q.size() == 0) check("aw_unexpected", 1, 0);
        else begin
          ea = aw_q.pop_front();
          check("awaddr", awaddr, ea.addr);
          check("awlen", awlen, ea.len);
        end
      end
      if (wvalid && mem_wready_i) begin
        w_seen++;
        if (w_q.size() == 0) check("w_unexpected", 1, 0);
        else begin
          ew = w_q.pop_front();
          check("wdata", wdata, ew.data);
          check("wstrb", wstrb, ew.strb);
          check("wlast", wlast, ew.last);
        end
      end
      if (pkt_done_o) begin
        check("busy_at_done", busy_o, 0);
        if (done_q.size() == 0) check("done_unexpected", 1, 0);
        else begin
          ed = done_q.pop_front();
          check("pkt_size", pkt_size_o, ed.size);
          check("truncated", truncated_o, ed.trunc);
          check("err", err_o, ed.err);
        end
      end
      if (awvalid || wvalid) check("tready_during_burst", pkt_tready_o, 0);
    end
  end

  // Memory-side responders.
  initial forever begin
    @(posedge clk_i); #1;
    if (aw_stall > 0 && awvalid) begin mem_awready_i = 1'b0; aw_stall--; end
    else if (aw_rand) mem_awready_i = 1'($urandom_range(0, 1));
    else mem_awready_i = 1'b1;
  end

  initial forever begin
    @(posedge clk_i); #1;
    mem_wready_i = w_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  initial forever begin
    @(negedge clk_i);
    if (!rst_i && wvalid && mem_wready_i && wlast) begin
      @(posedge clk_i);
      repeat ($urandom_range(0, 3)) @(posedge clk_i);
      #1;
      if (bresp_q.size() != 0) mem_bresp_i = bresp_q.pop_front();
      else mem_bresp_i = 2'b00;
      mem_bvalid_i = 1'b1;
      @(posedge clk_i); #1;
      mem_bvalid_i = 1'b0;
      mem_bresp_i  = 2'b00;
    end
  end

  task automatic send_beat(logic [DW-1:0] d, logic [7:0] k, logic l);
    int budget = 0;
    if (gap_rand) repeat ($urandom_range(0, 1)) begin @(posedge clk_i); #1; end
    pkt_tvalid_i = 1'b1; pkt_tdata_i = d; pkt_tkeep_i = k; pkt_tlast_i = l;
    @(negedge clk_i);
    while (!pkt_tready_o && budget < 3000) begin @(negedge clk_i); budget++; end
    check("beat_accepted", pkt_tready_o, 1);
    @(posedge clk_i); #1;
    pkt_tvalid_i = 1'b0; pkt_tlast_i = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (done_q.size() != 0 && t < 20000) begin @(posedge clk_i); t++; end
    #1;
    check("done_seen", done_q.size(), 0);
    done_q.delete();
    check("aw_drained", aw_q.size(), 0);
    check("w_drained", w_q.size(), 0);
  endtask

  // Reference model: which words land where, derived from packet length and limits.
  task automatic send_pkt(int n, int k, logic [AWD-1:0] base, int err_burst, bit expect_done);
    logic [DW-1:0] d[$];
    logic [7:0]    kmask, fstrb;
    int            stored, nb, blen;
    bit            trunc;
    aw_t ea; w_t ew; done_t ed;
    trunc  = (n > MAXW);
    stored = trunc ? MAXW : n;
    kmask  = 8'((1 << k) - 1);
    fstrb  = trunc ? 8'hFF : kmask;
    nb     = (stored + 255) / 256;
    for (int b = 0; b < nb; b++) begin
      blen = (stored - b * 256 > 256) ? 256 : stored - b * 256;
      ea.addr = base + AWD'(b * 2048);
      ea.len  = 8'(blen - 1);
      aw_q.push_back(ea);
      bresp_q.push_back((b == err_burst) ? 2'b10 : 2'b00);
    end
    for (int i = 0; i < n; i++) begin
      d.push_back({$urandom, $urandom});
      if (i < stored) begin
        ew.data = d[i];
        ew.strb = (i == stored - 1) ? fstrb : 8'hFF;
        ew.last = (i % 256 == 255) || (i == stored - 1);
        w_q.push_back(ew);
      end
    end
    if (expect_done) begin
      ed.size  = trunc ? PSW'(MAXB) : PSW'((stored - 1) * 8 + k);
      ed.trunc = trunc;
      ed.err   = (err_burst >= 0) && (err_burst < nb);
      done_q.push_back(ed);
    end
    addr_i = base; wr_stb_i = 1'b1;
    @(posedge clk_i); #1;
    wr_stb_i = 1'b0;
    check("busy_after_stb", busy_o, 1);
    check("err_cleared", err_o, 0);
    check("trunc_cleared", truncated_o, 0);
    for (int i = 0; i < n; i++)
      send_beat(d[i], (i == n - 1) ? kmask : 8'hFF, i == n - 1);
    if (expect_done) wait_done();
  endtask

  initial begin
    int t, base_seen;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_busy", busy_o, 0);
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_tready", pkt_tready_o, 0);
    check("rst_done", pkt_done_o, 0);
    check("rst_size", pkt_size_o, 0);
    check("rst_bready", bready, 1);
    check("rst_rready", rready, 1);
    check("rst_arvalid", arvalid, 0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    send_pkt(8, 8, 32'h1000, -1, 1);          // 64 bytes, single burst
    send_pkt(2, 5, 32'h2000, -1, 1);          // 13 bytes
    send_pkt(376, 1, 32'h0, -1, 1);           // 3001 bytes, two bursts
    send_pkt(MAXW + 44, 4, 32'h4000, -1, 1);  // truncated, 44 beats dropped
    send_pkt(256, 8, 32'h8000, -1, 1);        // tlast on a burst boundary
    send_pkt(MAXW, 3, 32'h10000, -1, 1);      // tlast on the max word
    send_pkt(257, 2, 32'h18000, -1, 1);

    aw_stall = 10; w_rand = 1;                // backpressure + SLVERR
    send_pkt(40, 6, 32'h20000, 0, 1);
    w_rand = 0;
    send_pkt(3, 7, 32'h21000, -1, 1);         // err_o must be cleared again

    send_pkt(40, 8, 32'h6000, -1, 0);         // reset mid-DATA_S
    base_seen = w_seen; t = 0;
    while (w_seen < base_seen + 5 && t < 2000) begin @(negedge clk_i); t++; end
    check("w_started", (w_seen >= base_seen + 5), 1);
    #1 rst_i = 1'b1;
    #1;
    check("midrst_awvalid", awvalid, 0);
    check("midrst_wvalid", wvalid, 0);
    check("midrst_busy", busy_o, 0);
    aw_q.delete(); w_q.delete(); bresp_q.delete();
    @(posedge clk_i); #1 rst_i = 1'b0;
    @(posedge clk_i); #1;
    send_pkt(20, 3, 32'h6000, -1, 1);

    aw_rand = 1; w_rand = 1; gap_rand = 1;
    for (int p = 0; p < 8; p++)
      send_pkt($urandom_range(1, 560), $urandom_range(1, 8), AWD'($urandom_range(0, 4095)) << 11,
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
